// File: rtl/mapas_pkg.sv
// Shared types for the sample scheduler feeding the mapas occupancy-grid builder.
package mapas_pkg;

  localparam int unsigned TAM_DIST = 4;
  localparam int unsigned CONT_W   = 16;

  typedef struct packed {
    logic [TAM_DIST-1:0] x;
    logic [TAM_DIST-1:0] y;
    logic                direcao;
    logic [TAM_DIST-1:0] distDireita;
    logic [TAM_DIST-1:0] distEsquerda;
  } amostra_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENVIA    = 2'd1,
    PROCESSA = 2'd2
  } estado_escalonador_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CONT_W-1:0] incSatura(input logic [CONT_W-1:0] valor);
    return (valor == '1) ? valor : valor + CONT_W'(1);
  endfunction

endpackage

// File: rtl/fila_amostras.sv
// Synchronous sample FIFO; a write into a full FIFO or a read from an empty one is ignored.
module fila_amostras
  import mapas_pkg::*;
#(
  parameter int unsigned Profundidade = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  amostra_t                        dadoEntrada,
  output amostra_t                        dadoSaida,
  output logic                            cheia,
  output logic                            vazia,
  output logic [$clog2(Profundidade):0]   contagem
);

  localparam int unsigned PtrW  = $clog2(Profundidade);
  localparam int unsigned ContW = PtrW + 1;

  amostra_t            memoria [Profundidade];
  logic [PtrW-1:0]     ptrEscrita;
  logic [PtrW-1:0]     ptrLeitura;
  logic                escreve;
  logic                le;

  assign cheia     = (contagem == ContW'(Profundidade));
  assign vazia     = (contagem == '0);
  assign escreve   = push && !cheia;
  assign le        = pop && !vazia;
  assign dadoSaida = memoria[ptrLeitura];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (escreve) begin
      memoria[ptrEscrita] <= dadoEntrada;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptrEscrita <= '0;
      ptrLeitura <= '0;
      contagem   <= '0;
    end else begin
      if (escreve) begin
        ptrEscrita <= ptrEscrita + PtrW'(1);
      end
      if (le) begin
        ptrLeitura <= ptrLeitura + PtrW'(1);
      end
      case ({escreve, le})
        2'b10:   contagem <= contagem + ContW'(1);
        2'b01:   contagem <= contagem - ContW'(1);
        default: contagem <= contagem;
      endcase
    end
  end

endmodule

// File: rtl/escalonador_amostras.sv
// Queues sensor samples and hands them one at a time to mapas through the
// novoDado/operacaoFinalizada handshake, with watchdog and event counters.
module escalonador_amostras
  import mapas_pkg::*;
#(
  parameter int unsigned TamanhoMalha     = 9,
  parameter int unsigned tamanhoDistancia = 4,
  parameter int unsigned ProfundidadeFila = 4,
  parameter int unsigned LimiteTimeout    = 1023
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        amostraValida,
  output logic                        amostraPronta,
  input  logic [tamanhoDistancia-1:0] amostraX,
  input  logic [tamanhoDistancia-1:0] amostraY,
  input  logic                        amostraDirecao,
  input  logic [tamanhoDistancia-1:0] amostraDistDireita,
  input  logic [tamanhoDistancia-1:0] amostraDistEsquerda,
  output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
  output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
  output logic                        direcaoAtual,
  output logic [tamanhoDistancia-1:0] distanciaDireita,
  output logic [tamanhoDistancia-1:0] distanciaEsquerda,
  output logic                        novoDado,
  input  logic                        operacaoFinalizada,
  input  logic                        limparErro,
  output logic                        ocupado,
  output logic                        erroTimeout,
  output logic [CONT_W-1:0]           contProcessadas,
  output logic [CONT_W-1:0]           contDescartadas,
  output logic [CONT_W-1:0]           contTimeouts
);

  localparam int unsigned TimerW    = $clog2(LimiteTimeout + 1);
  localparam int unsigned ContagemW = $clog2(ProfundidadeFila) + 1;

  estado_escalonador_t   estado;
  estado_escalonador_t   estadoProx;
  logic [TimerW-1:0]     timer;
  logic [TimerW-1:0]     timerProx;
  logic                  novoDadoProx;
  logic                  popFila;
  logic                  carrega;
  logic                  fimOk;
  logic                  estouro;
  logic                  limiteAtingido;

  amostra_t              amostraEntrada;
  amostra_t              cabeca;
  logic                  aceita;
  logic                  dentroMalha;
  logic                  pushFila;
  logic                  descarta;
  logic                  filaCheia;
  logic                  filaVazia;
  logic [ContagemW-1:0]  contagemFila;

  always_comb begin
    amostraEntrada.x            = TAM_DIST'(amostraX);
    amostraEntrada.y            = TAM_DIST'(amostraY);
    amostraEntrada.direcao      = amostraDirecao;
    amostraEntrada.distDireita  = TAM_DIST'(amostraDistDireita);
    amostraEntrada.distEsquerda = TAM_DIST'(amostraDistEsquerda);
  end

  // Out-of-grid positions are counted and dropped before reaching the FIFO.
  assign amostraPronta  = !filaCheia;
  assign aceita         = amostraValida && amostraPronta;
  assign dentroMalha    = (32'(amostraX) < TamanhoMalha) && (32'(amostraY) < TamanhoMalha);
  assign pushFila       = aceita && dentroMalha;
  assign descarta       = aceita && !dentroMalha;
  assign ocupado        = (estado != OCIOSO) || (contagemFila != '0);
  assign limiteAtingido = (timer == TimerW'(LimiteTimeout));

  fila_amostras #(
    .Profundidade (ProfundidadeFila)
  ) uFila (
    .clock       (clock),
    .reset       (reset),
    .push        (pushFila),
    .pop         (popFila),
    .dadoEntrada (amostraEntrada),
    .dadoSaida   (cabeca),
    .cheia       (filaCheia),
    .vazia       (filaVazia),
    .contagem    (contagemFila)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estadoProx;
    end
  end

  always_comb begin
    estadoProx   = estado;
    timerProx    = timer;
    novoDadoProx = 1'b0;
    popFila      = 1'b0;
    carrega      = 1'b0;
    fimOk        = 1'b0;
    estouro      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (!filaVazia) begin
          popFila      = 1'b1;
          carrega      = 1'b1;
          novoDadoProx = 1'b1;
          timerProx    = '0;
          estadoProx   = ENVIA;
        end
      end
      ENVIA: begin
        novoDadoProx = 1'b1;
        if (!operacaoFinalizada) begin
          novoDadoProx = 1'b0;
          timerProx    = '0;
          estadoProx   = PROCESSA;
        end else if (limiteAtingido) begin
          novoDadoProx = 1'b0;
          estouro      = 1'b1;
          timerProx    = '0;
          estadoProx   = OCIOSO;
        end else begin
          timerProx = timer + TimerW'(1);
        end
      end
      PROCESSA: begin
        if (operacaoFinalizada) begin
          fimOk      = 1'b1;
          timerProx  = '0;
          estadoProx = OCIOSO;
        end else if (limiteAtingido) begin
          estouro    = 1'b1;
          timerProx  = '0;
          estadoProx = OCIOSO;
        end else begin
          timerProx = timer + TimerW'(1);
        end
      end
      default: begin
        estadoProx = OCIOSO;
        timerProx  = '0;
      end
    endcase
  end

  // Data outputs only change on a pop, so they hold through the whole handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      posicaoAtualnoEixoX <= '0;
      posicaoAtualnoEixoY <= '0;
      direcaoAtual        <= 1'b0;
      distanciaDireita    <= '0;
      distanciaEsquerda   <= '0;
      novoDado            <= 1'b0;
      timer               <= '0;
      erroTimeout         <= 1'b0;
      contProcessadas     <= '0;
      contDescartadas     <= '0;
      contTimeouts        <= '0;
    end else begin
      if (carrega) begin
        posicaoAtualnoEixoX <= tamanhoDistancia'(cabeca.x);
        posicaoAtualnoEixoY <= tamanhoDistancia'(cabeca.y);
        direcaoAtual        <= cabeca.direcao;
        distanciaDireita    <= tamanhoDistancia'(cabeca.distDireita);
        distanciaEsquerda   <= tamanhoDistancia'(cabeca.distEsquerda);
      end
      novoDado <= novoDadoProx;
      timer    <= timerProx;
      // A timeout in the same cycle as a clear request leaves the flag set.
      if (estouro) begin
        erroTimeout <= 1'b1;
      end else if (limparErro) begin
        erroTimeout <= 1'b0;
      end
      if (fimOk) begin
        contProcessadas <= incSatura(contProcessadas);
      end
      if (descarta) begin
        contDescartadas <= incSatura(contDescartadas);
      end
      if (estouro) begin
        contTimeouts <= incSatura(contTimeouts);
      end
    end
  end

endmodule

// File: tb/tb_escalonador_amostras.sv
// Scoreboard bench for escalonador_amostras with a behavioural mapas responder.
module tb_escalonador_amostras;
  import mapas_pkg::*;

  logic        clock;
  logic        reset;
  logic        amostraValida;
  logic        amostraPronta;
  logic [3:0]  amostraX;
  logic [3:0]  amostraY;
  logic        amostraDirecao;
  logic [3:0]  amostraDistDireita;
  logic [3:0]  amostraDistEsquerda;
  logic [3:0]  posicaoAtualnoEixoX;
  logic [3:0]  posicaoAtualnoEixoY;
  logic        direcaoAtual;
  logic [3:0]  distanciaDireita;
  logic [3:0]  distanciaEsquerda;
  logic        novoDado;
  logic        operacaoFinalizada;
  logic        limparErro;
  logic        ocupado;
  logic        erroTimeout;
  logic [15:0] contProcessadas;
  logic [15:0] contDescartadas;
  logic [15:0] contTimeouts;

  escalonador_amostras dut (
    .clock               (clock),
    .reset               (reset),
    .amostraValida       (amostraValida),
    .amostraPronta       (amostraPronta),
    .amostraX            (amostraX),
    .amostraY            (amostraY),
    .amostraDirecao      (amostraDirecao),
    .amostraDistDireita  (amostraDistDireita),
    .amostraDistEsquerda (amostraDistEsquerda),
    .posicaoAtualnoEixoX (posicaoAtualnoEixoX),
    .posicaoAtualnoEixoY (posicaoAtualnoEixoY),
    .direcaoAtual        (direcaoAtual),
    .distanciaDireita    (distanciaDireita),
    .distanciaEsquerda   (distanciaEsquerda),
    .novoDado            (novoDado),
    .operacaoFinalizada  (operacaoFinalizada),
    .limparErro          (limparErro),
    .ocupado             (ocupado),
    .erroTimeout         (erroTimeout),
    .contProcessadas     (contProcessadas),
    .contDescartadas     (contDescartadas),
    .contTimeouts        (contTimeouts)
  );

  int       checks = 0;
  int       errors = 0;
  amostra_t esperados[$];
  int       expProc = 0;
  int       expDesc = 0;
  int       expTimeouts = 0;
  int       subidas = 0;
  int       ciclo = 0;
  int       ultimaSubida = 0;
  bit       viuCheia = 0;
  bit       modoNunca = 0;
  int       atrasoQueda = 2;
  int       tempoOcupado = 5;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic checa(input string nome, input logic [31:0] atual, input logic [31:0] req);
    checks++;
    if (atual !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, req);
    end
  endtask

  // Monitor: every rising novoDado must present the oldest queued in-range sample.
  initial begin : monitor
    bit       anterior;
    amostra_t exp;
    anterior = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && novoDado && !anterior) begin
        subidas++;
        ultimaSubida = ciclo;
        if (esperados.size() == 0) begin
          checa("novoDadoInesperado", 32'(novoDado), 32'(0));
        end else begin
          exp = esperados.pop_front();
          checa("dadosMapas",
                32'({posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
                     distanciaDireita, distanciaEsquerda}),
                32'({exp.x, exp.y, exp.direcao, exp.distDireita, exp.distEsquerda}));
        end
      end
      if (!reset && !amostraPronta) viuCheia = 1'b1;
      anterior = reset ? 1'b0 : novoDado;
    end
  end

  // Behavioural mapas: drop operacaoFinalizada a few cycles after a request, stay busy, then release.
  initial begin : modeloMapas
    operacaoFinalizada = 1'b1;
    forever begin
      @(negedge clock);
      if (!modoNunca && novoDado && !reset) begin
        repeat (atrasoQueda) @(negedge clock);
        operacaoFinalizada = 1'b0;
        repeat (tempoOcupado) @(negedge clock);
        operacaoFinalizada = 1'b1;
      end
    end
  end

  task automatic envia(input logic [3:0] x, input logic [3:0] y, input logic d,
                       input logic [3:0] dr, input logic [3:0] de);
    bit       aceito;
    bit       pronta;
    amostra_t e;
    amostraX = x; amostraY = y; amostraDirecao = d;
    amostraDistDireita = dr; amostraDistEsquerda = de;
    amostraValida = 1'b1;
    aceito = 1'b0;
    for (int i = 0; i < 2000 && !aceito; i++) begin
      pronta = amostraPronta;
      @(posedge clock);
      if (pronta) aceito = 1'b1;
      else @(negedge clock);
    end
    if (!aceito) begin
      checa("enviaAceite", 32'(0), 32'(1));
    end else if (int'(x) < 9 && int'(y) < 9) begin
      e.x = x; e.y = y; e.direcao = d; e.distDireita = dr; e.distEsquerda = de;
      esperados.push_back(e);
    end else begin
      expDesc++;
    end
    @(negedge clock);
    amostraValida = 1'b0;
  endtask

  task automatic esperaOcioso(input int limite);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limite && !ok; i++) begin
      @(negedge clock);
      if (!ocupado && operacaoFinalizada && !novoDado) ok = 1'b1;
    end
    checa("esperaOcioso", 32'(ok), 32'(1));
    checa("filaEsperadosVazia", 32'(esperados.size()), 32'(0));
  endtask

  task automatic esperaErro(input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite && !ok; i++) begin
      @(negedge clock);
      if (erroTimeout) ok = 1'b1;
    end
    checa("esperaTimeout", 32'(ok), 32'(1));
  endtask

  task automatic checaContadores(input string nome);
    checa({nome, "_processadas"}, 32'(contProcessadas), 32'(expProc));
    checa({nome, "_descartadas"}, 32'(contDescartadas), 32'(expDesc));
    checa({nome, "_timeouts"},    32'(contTimeouts),    32'(expTimeouts));
  endtask

  initial begin : estimulo
    bit ok;
    int nDentro;
    int subidasAntes;
    logic [3:0] rx, ry;
    reset = 1'b1; amostraValida = 1'b0; limparErro = 1'b0;
    amostraX = '0; amostraY = '0; amostraDirecao = 1'b0;
    amostraDistDireita = '0; amostraDistEsquerda = '0;
    repeat (3) @(negedge clock);
    checa("reset_novoDado", 32'(novoDado), 32'(0));
    checa("reset_dados", 32'({posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
                              distanciaDireita, distanciaEsquerda}), 32'(0));
    checa("reset_pronta", 32'(amostraPronta), 32'(1));
    checa("reset_ocupado", 32'(ocupado), 32'(0));
    checa("reset_erro", 32'(erroTimeout), 32'(0));
    checaContadores("reset");
    reset = 1'b0;
    @(negedge clock);

    // Single sample: latency and full handshake.
    envia(4'd2, 4'd0, 1'b0, 4'd0, 4'd0);
    checa("latencia_antes", 32'(novoDado), 32'(0));
    @(negedge clock);
    checa("latencia_novoDado", 32'(novoDado), 32'(1));
    checa("latencia_XY", 32'({posicaoAtualnoEixoX, posicaoAtualnoEixoY}), 32'(8'h20));
    esperaOcioso(100);
    expProc += 1;
    checaContadores("umaAmostra");
    checa("umaAmostra_ocupado", 32'(ocupado), 32'(0));

    // Back-to-back burst against a slow mapas.
    tempoOcupado = 20;
    viuCheia = 1'b0;
    for (int i = 0; i < 6; i++) begin
      envia(4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    esperaOcioso(1000);
    expProc += 6;
    checa("rajada_viuCheia", 32'(viuCheia), 32'(1));
    checaContadores("rajada");

    // Out-of-grid positions are discarded.
    subidasAntes = subidas;
    envia(4'd9, 4'd3, 1'b1, 4'd1, 4'd1);
    envia(4'd4, 4'd12, 1'b0, 4'd2, 4'd2);
    repeat (5) @(negedge clock);
    checa("descarte_subidas", 32'(subidas), 32'(subidasAntes));
    checa("descarte_ocupado", 32'(ocupado), 32'(0));
    checaContadores("descarte");

    // Random mix of valid and out-of-range samples with gaps.
    nDentro = 0;
    for (int i = 0; i < 10; i++) begin
      tempoOcupado = int'($urandom_range(1, 6));
      rx = 4'($urandom_range(0, 11));
      ry = 4'($urandom_range(0, 11));
      if (int'(rx) < 9 && int'(ry) < 9) nDentro++;
      envia(rx, ry, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    esperaOcioso(2000);
    expProc += nDentro;
    checaContadores("aleatorio");

    // Watchdog in ENVIA: mapas never answers, next queued sample is still served.
    modoNunca = 1'b1;
    tempoOcupado = 5;
    envia(4'd1, 4'd1, 1'b1, 4'd3, 4'd4);
    envia(4'd5, 4'd6, 1'b0, 4'd7, 4'd8);
    esperaErro(1200, ok);
    expTimeouts = 1;
    checa("timeout1_ciclos", 32'(ciclo - ultimaSubida), 32'(1024));
    checa("timeout1_novoDado", 32'(novoDado), 32'(0));
    checa("timeout1_cont", 32'(contTimeouts), 32'(1));
    modoNunca = 1'b0;
    esperaOcioso(200);
    expProc += 1;
    checaContadores("timeout1");
    checa("timeout1_erroRetido", 32'(erroTimeout), 32'(1));
    limparErro = 1'b1;
    @(negedge clock);
    limparErro = 1'b0;
    checa("limparErro", 32'(erroTimeout), 32'(0));

    // Clear held while a second timeout fires: the set wins.
    limparErro = 1'b1;
    modoNunca = 1'b1;
    envia(4'd8, 4'd8, 1'b1, 4'd15, 4'd0);
    esperaErro(1200, ok);
    limparErro = 1'b0;
    expTimeouts = 2;
    checa("timeout2_cont", 32'(contTimeouts), 32'(2));
    @(negedge clock);
    checa("timeout2_erro", 32'(erroTimeout), 32'(1));
    modoNunca = 1'b0;
    checaContadores("timeout2");

    // Reset mid-handshake with queued samples.
    tempoOcupado = 40;
    envia(4'd3, 4'd4, 1'b0, 4'd5, 4'd6);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (!novoDado && !operacaoFinalizada) ok = 1'b1;
    end
    checa("reset_emProcessa", 32'(ok), 32'(1));
    envia(4'd0, 4'd1, 1'b1, 4'd2, 4'd3);
    envia(4'd7, 4'd7, 1'b0, 4'd1, 4'd1);
    envia(4'd6, 4'd2, 1'b1, 4'd9, 4'd9);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    esperados.delete();
    expProc = 0; expDesc = 0; expTimeouts = 0;
    checa("resetMeio_novoDado", 32'(novoDado), 32'(0));
    checa("resetMeio_ocupado", 32'(ocupado), 32'(0));
    checa("resetMeio_pronta", 32'(amostraPronta), 32'(1));
    checa("resetMeio_erro", 32'(erroTimeout), 32'(0));
    checaContadores("resetMeio");
    subidasAntes = subidas;
    repeat (100) @(negedge clock);
    checa("resetMeio_semSubida", 32'(subidas), 32'(subidasAntes));
    checaContadores("resetMeioFinal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escalonador_amostras.md
Name: escalonador_amostras

Overview:
- Sequences sensor samples (robot position, heading, left/right distances) into the `mapas` occupancy-grid builder, one update at a time.
- Buffers incoming samples in a small FIFO and drops samples whose position lies outside the grid.
- Drives the `novoDado`/`operacaoFinalizada` handshake of `mapas`.
- Provides a timeout watchdog plus processed, discarded and timeout counters.

Parameters:
- TamanhoMalha, 9, grid side length; a valid coordinate is 0..TamanhoMalha-1.
- tamanhoDistancia, 4, bit width of each position and distance field.
- ProfundidadeFila, 4, FIFO depth in samples (power of two, >=2).
- LimiteTimeout, 1023, maximum cycles allowed in any handshake wait state.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- amostraValida  in  1  upstream sample valid.
- amostraPronta  out  1  FIFO can accept a sample (= !cheia).
- amostraX  in  tamanhoDistancia  sample X position.
- amostraY  in  tamanhoDistancia  sample Y position.
- amostraDirecao  in  1  sample heading.
- amostraDistDireita  in  tamanhoDistancia  right distance.
- amostraDistEsquerda  in  tamanhoDistancia  left distance.
- posicaoAtualnoEixoX  out  tamanhoDistancia  to mapas.
- posicaoAtualnoEixoY  out  tamanhoDistancia  to mapas.
- direcaoAtual  out  1  to mapas.
- distanciaDireita  out  tamanhoDistancia  to mapas.
- distanciaEsquerda  out  tamanhoDistancia  to mapas.
- novoDado  out  1  request to mapas.
- operacaoFinalizada  in  1  from mapas; low = busy, high = done/idle.
- limparErro  in  1  clears erroTimeout.
- ocupado  out  1  FSM not in OCIOSO, or FIFO non-empty.
- erroTimeout  out  1  sticky timeout flag.
- contProcessadas  out  16  updates completed.
- contDescartadas  out  16  samples rejected for out-of-range position.
- contTimeouts  out  16  handshakes aborted by timeout.

Behaviour:
- Reset (synchronous): FIFO emptied, FSM=OCIOSO, novoDado=0, all mapas data outputs=0, erroTimeout=0, all counters=0, timer=0, amostraPronta=1, ocupado=0. Reset applied mid-handshake aborts the handshake with no counter update.
- Push: when amostraValida & amostraPronta at an edge:
  - If X<TamanhoMalha and Y<TamanhoMalha, write the sample to FIFO.
  - Otherwise do not write, and increment contDescartadas.
- amostraPronta=0 when FIFO is full, even if a pop occurs in the same cycle (no full-pass-through).
- Pop and push in the same cycle are allowed when not full. FIFO pointers wrap modulo ProfundidadeFila.
- FSM states: OCIOSO, ENVIA, PROCESSA.
- OCIOSO:
  - If FIFO is non-empty: pop the head, register it onto the mapas data outputs, set novoDado=1, timer=0, go to ENVIA.
  - Data outputs hold their last value otherwise.
- ENVIA:
  - novoDado=1.
  - If operacaoFinalizada==0 (mapas accepted the request): novoDado=0, timer=0, go to PROCESSA.
  - Else if timer==LimiteTimeout: timeout (see below).
  - Else timer++.
- PROCESSA:
  - novoDado=0.
  - If operacaoFinalizada==1: contProcessadas++, go to OCIOSO.
  - Else if timer==LimiteTimeout: timeout.
  - Else timer++.
- Timeout: novoDado=0, erroTimeout=1, contTimeouts++, sample dropped, go to OCIOSO.
- Latency: sample accepted at edge k into an empty FIFO with FSM in OCIOSO → novoDado=1 and data outputs valid after edge k+1. Back-to-back samples need a minimum of 3 cycles per update (OCIOSO→ENVIA→PROCESSA→OCIOSO) plus mapas busy time.
- Data outputs stay stable from leaving OCIOSO until the next pop.
- limparErro clears erroTimeout at the next edge. If a timeout occurs in the same cycle, set wins.
- All counters saturate at 16'hFFFF (no wrap).
- Simultaneous discard and timeout in one cycle: both counters increment independently.

Decomposition:
- Package `mapas_pkg`:
  - `amostra_t` packed struct {x, y, direcao, distDireita, distEsquerda}, parameterised by width constant TAM_DIST=4.
  - `estado_escalonador_t` enum {OCIOSO, ENVIA, PROCESSA}.
  - Constant CONT_W=16.
- Sub-module `fila_amostras`: synchronous FIFO of `amostra_t`, with ports push/pop/cheia/vazia and a registered count.
- The FSM, validation, watchdog and counters live in the top module.

Test Plan:
- Reset then one sample (X=2, Y=0, dir=0, D=E=0) with mapas model dropping opFin 2 cycles after novoDado and raising it 5 cycles later → novoDado=1 one cycle after push, outputs X=2/Y=0, novoDado falls, contProcessadas=1, ocupado=0 at end.
- Push 6 samples back-to-back with mapas busy 20 cycles, depth 4 → amostraPronta low after the FIFO fills. All 6 samples eventually issued in FIFO order, contProcessadas=6, none lost.
- Push X=9, Y=3 then X=4, Y=12 → contDescartadas=2, FIFO stays empty, novoDado never asserts.
- mapas never drops operacaoFinalizada → after 1024 cycles in ENVIA: erroTimeout=1, contTimeouts=1, novoDado=0, FSM returns to OCIOSO and serves the next queued sample. limparErro pulse → erroTimeout=0.
- Assert reset for 1 cycle while in PROCESSA with 3 queued samples → after the edge: novoDado=0, FIFO empty, all counters 0, no spurious update afterwards.
- limparErro asserted in the same cycle as a second timeout → erroTimeout stays 1, contTimeouts=2.
